alu_ctrl_fsm: RTL and testbench



---
 rtl/alu_ctrl_fsm_pkg.sv | 78 +++++++
 rtl/alu_ctrl_fsm_if.sv | 35 +++
 rtl/alu_ctrl_fsm_op_decode.sv | 49 ++++
 rtl/alu_ctrl_fsm.sv | 163 ++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared constants and types for the multicycle ALU control unit and its decoder.
package alu_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMACC = 3'd4,
    S_WBACK  = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Instruction classes as seen by the sequencer
  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_RALU = 3'd1,
    C_IALU = 3'd2,
    C_LW   = 3'd3,
    C_SW   = 3'd4,
    C_BEQ  = 3'd5,
    C_BNE  = 3'd6,
    C_J    = 3'd7
  } iclass_e;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_BNE  = 6'h05;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_XORI = 6'h0E;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;

  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;

  localparam logic [1:0] PCS_ALU = 2'd0;
  localparam logic [1:0] PCS_BR  = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;
  localparam logic [1:0] PCS_EXC = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OF   = 2'b01;
  localparam logic [1:0] EXC_ILL  = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  typedef struct packed {
    logic [2:0] alu_op;    // op to use in EXEC
    logic       ext_zero;  // zero-extend the immediate
    iclass_e    cls;
    logic       illegal;
    logic       of_chk;    // add/sub/addi: overflow is meaningful
  } dec_t;

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Control/flag bundle between the sequencer (master) and the datapath (slave).
interface alu_ctrl_fsm_if;
  logic [31:0] INSTR;
  logic        ZF;
  logic        OF;
  logic        MEM_RDY;
  logic [2:0]  ALU_OP;
  logic        ALU_SRC_A;
  logic [1:0]  ALU_SRC_B;
  logic        EXT_ZERO;
  logic        PC_WE;
  logic        IR_WE;
  logic        REG_WE;
  logic        ALUOUT_WE;
  logic [1:0]  PC_SRC;
  logic        REG_DST;
  logic        MEM_TO_REG;
  logic        MEM_RD;
  logic        MEM_WR;
  logic        EXC;
  logic [1:0]  EXC_CAUSE;
  logic [2:0]  STATE;

  modport master (
    input  INSTR, ZF, OF, MEM_RDY,
    output ALU_OP, ALU_SRC_A, ALU_SRC_B, EXT_ZERO, PC_WE, IR_WE, REG_WE, ALUOUT_WE,
           PC_SRC, REG_DST, MEM_TO_REG, MEM_RD, MEM_WR, EXC, EXC_CAUSE, STATE
  );

  modport slave (
    output INSTR, ZF, OF, MEM_RDY,
    input  ALU_OP, ALU_SRC_A, ALU_SRC_B, EXT_ZERO, PC_WE, IR_WE, REG_WE, ALUOUT_WE,
           PC_SRC, REG_DST, MEM_TO_REG, MEM_RD, MEM_WR, EXC, EXC_CAUSE, STATE
  );
endinterface

// File: rtl/alu_ctrl_fsm_op_decode.sv
// Combinational instruction decoder: INSTR -> ALU op, immediate extension, class, illegal.
// Kept free of sequencing so a pipelined core can reuse it as-is.
module alu_op_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opc, fn;
  assign opc = instr[31:26];
  assign fn  = instr[5:0];

  // Table decode; anything not listed stays illegal (addu, addiu, ... included)
  always_comb begin
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.cls      = C_NONE;
    dec.illegal  = 1'b1;
    case (opc)
      OPC_R: begin
        dec.cls     = C_RALU;
        dec.illegal = 1'b0;
        case (fn)
          FN_ADD:  begin dec.alu_op = ALU_ADD; dec.of_chk = 1'b1; end
          FN_SUB:  begin dec.alu_op = ALU_SUB; dec.of_chk = 1'b1; end
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_SLTU: dec.alu_op = ALU_SLTU;
          FN_SLLV: dec.alu_op = ALU_SLLV;
          default: begin dec.cls = C_NONE; dec.illegal = 1'b1; end
        endcase
      end
      OPC_ADDI: begin dec.cls = C_IALU; dec.illegal = 1'b0; dec.of_chk = 1'b1; end
      OPC_ANDI: begin dec.cls = C_IALU; dec.illegal = 1'b0; dec.alu_op = ALU_AND; dec.ext_zero = 1'b1; end
      OPC_ORI:  begin dec.cls = C_IALU; dec.illegal = 1'b0; dec.alu_op = ALU_OR;  dec.ext_zero = 1'b1; end
      OPC_XORI: begin dec.cls = C_IALU; dec.illegal = 1'b0; dec.alu_op = ALU_XOR; dec.ext_zero = 1'b1; end
      OPC_LW:   begin dec.cls = C_LW;   dec.illegal = 1'b0; end
      OPC_SW:   begin dec.cls = C_SW;   dec.illegal = 1'b0; end
      OPC_BEQ:  begin dec.cls = C_BEQ;  dec.illegal = 1'b0; dec.alu_op = ALU_SUB; end
      OPC_BNE:  begin dec.cls = C_BNE;  dec.illegal = 1'b0; dec.alu_op = ALU_SUB; end
      OPC_J:    begin dec.cls = C_J;    dec.illegal = 1'b0; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEMACC/WBACK/TRAP and
// steers the datapath muxes/enables around the ALU.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter bit          TRAP_ON_OF      = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 0
)(
  input  logic           CLK,
  input  logic           RST_N,
  alu_ctrl_fsm_if.master bus
);

  localparam bit         TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       tmo_hit;
  dec_t       dec;

  alu_op_decode u_dec (.instr(bus.INSTR), .dec(dec));

  // Expiry only on a low cycle, so a same-cycle MEM_RDY completion wins
  assign tmo_hit = TMO_EN && !bus.MEM_RDY && (cnt_q == TMO_LAST);

  assign bus.EXC_CAUSE = cause_q;
  assign bus.STATE     = state_q;

  // State, wait counter and trap cause registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    bus.ALU_OP     = ALU_ADD;
    bus.ALU_SRC_A  = 1'b0;
    bus.ALU_SRC_B  = SRCB_REG;
    bus.EXT_ZERO   = 1'b0;
    bus.PC_WE      = 1'b0;
    bus.IR_WE      = 1'b0;
    bus.REG_WE     = 1'b0;
    bus.ALUOUT_WE  = 1'b0;
    bus.PC_SRC     = PCS_ALU;
    bus.REG_DST    = 1'b0;
    bus.MEM_TO_REG = 1'b0;
    bus.MEM_RD     = 1'b0;
    bus.MEM_WR     = 1'b0;
    bus.EXC        = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        bus.MEM_RD    = 1'b1;
        bus.ALU_SRC_B = SRCB_4;
        if (bus.MEM_RDY) begin
          bus.IR_WE = 1'b1;
          bus.PC_WE = 1'b1;
          state_d   = S_DECODE;
        end else if (tmo_hit) begin
          // PC stays put: the trap vector write is the only PC update
          state_d = S_TRAP;
          cause_d = EXC_BUS;
        end
      end

      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        bus.ALU_SRC_B = SRCB_BR;
        bus.ALUOUT_WE = 1'b1;
        if (dec.cls == C_J) begin
          bus.PC_WE  = 1'b1;
          bus.PC_SRC = PCS_JMP;
          state_d    = S_FETCH;
        end else if (dec.illegal) begin
          if (TRAP_ON_ILLEGAL) begin
            state_d = S_TRAP;
            cause_d = EXC_ILL;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        bus.ALU_SRC_A = 1'b1;
        bus.ALU_OP    = dec.alu_op;
        bus.EXT_ZERO  = dec.ext_zero;
        case (dec.cls)
          C_BEQ, C_BNE: begin
            bus.ALU_SRC_B = SRCB_REG;
            bus.PC_SRC    = PCS_BR;
            bus.PC_WE     = (dec.cls == C_BEQ) ? bus.ZF : !bus.ZF;
            state_d       = S_FETCH;
          end
          C_RALU: begin
            bus.ALU_SRC_B = SRCB_REG;
            bus.ALUOUT_WE = 1'b1;
            state_d       = S_WBACK;
          end
          default: begin
            bus.ALU_SRC_B = SRCB_IMM;
            bus.ALUOUT_WE = 1'b1;
            state_d       = (dec.cls == C_LW || dec.cls == C_SW) ? S_MEMACC : S_WBACK;
          end
        endcase
        // Overflow trap preempts writeback, so REG_WE is never issued
        if (TRAP_ON_OF && dec.of_chk && bus.OF) begin
          state_d = S_TRAP;
          cause_d = EXC_OF;
        end
      end

      S_MEMACC: begin
        bus.MEM_RD = (dec.cls == C_LW);
        bus.MEM_WR = (dec.cls == C_SW);
        if (bus.MEM_RDY) begin
          state_d = (dec.cls == C_LW) ? S_WBACK : S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = EXC_BUS;
        end
      end

      S_WBACK: begin
        bus.REG_WE     = 1'b1;
        bus.REG_DST    = (dec.cls == C_RALU);
        bus.MEM_TO_REG = (dec.cls == C_LW);
        state_d        = S_FETCH;
      end

      S_TRAP: begin
        bus.EXC    = 1'b1;
        bus.PC_WE  = 1'b1;
        bus.PC_SRC = PCS_EXC;
        state_d    = S_FETCH;
      end

      default: state_d = S_RESET;
    endcase

    // Counter restarts on every entry to a request state, counts low cycles while waiting
    if ((state_q == S_FETCH || state_q == S_MEMACC) && state_d == state_q) cnt_d = cnt_q + 8'd1;
    else                                                                 cnt_d = '0;
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized bench for alu_ctrl_fsm: two instances with different trap/timeout
// settings, each checked cycle by cycle against scripts built from the
// instruction-level behaviour (class table, latencies, flags).
module tb_alu_ctrl_fsm;
  import alu_ctrl_fsm_pkg::*;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext_zero;
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       aluout_we;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_rd;
    logic       mem_wr;
    logic       exc;
    logic [1:0] exc_cause;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic        zf;
    logic        of;
    logic        rdy;
    obs_t        exp;
    obs_t        msk;
    logic [2:0]  st;
    string       tag;
  } step_t;

  logic        CLK = 1'b0;
  logic        rst_n_v [2];
  logic [31:0] instr_v [2];
  logic        zf_v [2];
  logic        of_v [2];
  logic        rdy_v [2];
  obs_t        obs_v [2];
  logic [2:0]  st_v [2];

  int   n_chk = 0;
  int   n_fail = 0;
  step_t q [$];
  obs_t e, m;
  logic [1:0] m_cause [2];
  bit   m_trap_of [2]  = '{1'b1, 1'b0};
  bit   m_trap_ill [2] = '{1'b1, 1'b0};
  int   m_tmo [2]      = '{0, 2};

  always #5 CLK = ~CLK;

  alu_ctrl_fsm_if bus_a ();
  alu_ctrl_fsm_if bus_b ();

  assign bus_a.INSTR = instr_v[0];
  assign bus_a.ZF = zf_v[0];
  assign bus_a.OF = of_v[0];
  assign bus_a.MEM_RDY = rdy_v[0];
  assign bus_b.INSTR = instr_v[1];
  assign bus_b.ZF = zf_v[1];
  assign bus_b.OF = of_v[1];
  assign bus_b.MEM_RDY = rdy_v[1];

  assign obs_v[0] = {bus_a.ALU_OP, bus_a.ALU_SRC_A, bus_a.ALU_SRC_B, bus_a.EXT_ZERO, bus_a.PC_WE,
                     bus_a.IR_WE, bus_a.REG_WE, bus_a.ALUOUT_WE, bus_a.PC_SRC, bus_a.REG_DST,
                     bus_a.MEM_TO_REG, bus_a.MEM_RD, bus_a.MEM_WR, bus_a.EXC, bus_a.EXC_CAUSE};
  assign obs_v[1] = {bus_b.ALU_OP, bus_b.ALU_SRC_A, bus_b.ALU_SRC_B, bus_b.EXT_ZERO, bus_b.PC_WE,
                     bus_b.IR_WE, bus_b.REG_WE, bus_b.ALUOUT_WE, bus_b.PC_SRC, bus_b.REG_DST,
                     bus_b.MEM_TO_REG, bus_b.MEM_RD, bus_b.MEM_WR, bus_b.EXC, bus_b.EXC_CAUSE};
  assign st_v[0] = bus_a.STATE;
  assign st_v[1] = bus_b.STATE;

  alu_ctrl_fsm #(.TRAP_ON_OF(1'b1), .TRAP_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(0)) dut_a (
    .CLK(CLK), .RST_N(rst_n_v[0]), .bus(bus_a.master));
  alu_ctrl_fsm #(.TRAP_ON_OF(1'b0), .TRAP_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(2)) dut_b (
    .CLK(CLK), .RST_N(rst_n_v[1]), .bus(bus_b.master));

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction table: class 0 illegal,1 R,2 I-ALU,3 lw,4 sw,5 beq,6 bne,7 j
  task automatic classify(input logic [31:0] ins, output int cls, output logic [2:0] aop,
                          output bit zx, output bit ovf);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    cls = 0; aop = 3'b100; zx = 0; ovf = 0;
    if (op == 6'h00) begin
      cls = 1;
      case (fn)
        6'h20: begin aop = 3'b100; ovf = 1; end
        6'h22: begin aop = 3'b101; ovf = 1; end
        6'h24: aop = 3'b000;
        6'h25: aop = 3'b001;
        6'h26: aop = 3'b010;
        6'h27: aop = 3'b011;
        6'h2B: aop = 3'b110;
        6'h04: aop = 3'b111;
        default: cls = 0;
      endcase
    end else begin
      case (op)
        6'h08: begin cls = 2; ovf = 1; end
        6'h0C: begin cls = 2; aop = 3'b000; zx = 1; end
        6'h0D: begin cls = 2; aop = 3'b001; zx = 1; end
        6'h0E: begin cls = 2; aop = 3'b010; zx = 1; end
        6'h23: cls = 3;
        6'h2B: cls = 4;
        6'h04: begin cls = 5; aop = 3'b101; end
        6'h05: begin cls = 6; aop = 3'b101; end
        6'h02: cls = 7;
        default: cls = 0;
      endcase
    end
  endtask

  // Fresh expectation: every enable/request low, enables and cause always compared
  task automatic new_step();
    e = '0;
    m = '0;
    m.pc_we = 1; m.ir_we = 1; m.reg_we = 1; m.aluout_we = 1;
    m.mem_rd = 1; m.mem_wr = 1; m.exc = 1; m.exc_cause = '1;
  endtask

  task automatic push(input int d, input string tag, input logic [2:0] st, input logic [31:0] ins,
                      input logic zf, input logic of, input logic rdy);
    step_t s;
    e.exc_cause = m_cause[d];
    s.instr = ins; s.zf = zf; s.of = of; s.rdy = rdy;
    s.exp = e; s.msk = m; s.st = st; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic trap(input int d, input logic [1:0] c, input logic [31:0] ins, input logic zf,
                      input logic of);
    m_cause[d] = c;
    new_step();
    e.exc = 1; e.pc_we = 1; e.pc_src = 2'd3; m.pc_src = '1;
    push(d, "trap", S_TRAP, ins, zf, of, 1'($urandom_range(0, 1)));
  endtask

  // One instruction from FETCH back to the next FETCH, given latencies and flags
  task automatic gen(input int d, input logic [31:0] ins, input int lf, input int lm,
                     input logic zf, input logic of);
    int cls; logic [2:0] aop; bit zx, ovf;
    classify(ins, cls, aop, zx, ovf);
    for (int k = 0; k < lf; k++) begin
      new_step();
      e.mem_rd = 1; e.alu_op = 3'b100; e.src_b = 2'd1;
      m.alu_op = '1; m.src_a = 1; m.src_b = '1; m.pc_src = '1;
      push(d, "fetch_wait", S_FETCH, ins, zf, of, 1'b0);
      if (m_tmo[d] != 0 && k + 1 == m_tmo[d]) begin trap(d, 2'b11, ins, zf, of); return; end
    end
    new_step();
    e.mem_rd = 1; e.alu_op = 3'b100; e.src_b = 2'd1; e.ir_we = 1; e.pc_we = 1;
    m.alu_op = '1; m.src_a = 1; m.src_b = '1; m.pc_src = '1;
    push(d, "fetch", S_FETCH, ins, zf, of, 1'b1);

    new_step();
    e.alu_op = 3'b100; e.src_b = 2'd3; e.aluout_we = 1;
    m.alu_op = '1; m.src_a = 1; m.src_b = '1;
    if (cls == 7) begin
      e.pc_we = 1; e.pc_src = 2'd2; m.pc_src = '1;
      push(d, "decode_j", S_DECODE, ins, zf, of, 1'($urandom_range(0, 1)));
      return;
    end
    push(d, "decode", S_DECODE, ins, zf, of, 1'($urandom_range(0, 1)));
    if (cls == 0) begin
      if (m_trap_ill[d]) trap(d, 2'b10, ins, zf, of);
      return;
    end

    new_step();
    e.src_a = 1; e.alu_op = aop; e.ext_zero = zx;
    m.src_a = 1; m.alu_op = '1; m.src_b = '1; m.ext_zero = 1;
    if (cls == 5 || cls == 6) begin
      e.src_b = 2'd0; e.pc_src = 2'd1; m.pc_src = '1;
      e.pc_we = (cls == 5) ? zf : !zf;
      push(d, "exec_br", S_EXEC, ins, zf, of, 1'($urandom_range(0, 1)));
      return;
    end
    e.src_b = (cls == 1) ? 2'd0 : 2'd2;
    e.aluout_we = 1;
    push(d, "exec", S_EXEC, ins, zf, of, 1'($urandom_range(0, 1)));
    if (ovf && of && m_trap_of[d]) begin trap(d, 2'b01, ins, zf, of); return; end

    if (cls == 3 || cls == 4) begin
      for (int k = 0; k < lm; k++) begin
        new_step();
        e.mem_rd = (cls == 3); e.mem_wr = (cls == 4);
        push(d, "memacc_wait", S_MEMACC, ins, zf, of, 1'b0);
        if (m_tmo[d] != 0 && k + 1 == m_tmo[d]) begin trap(d, 2'b11, ins, zf, of); return; end
      end
      new_step();
      e.mem_rd = (cls == 3); e.mem_wr = (cls == 4);
      push(d, "memacc", S_MEMACC, ins, zf, of, 1'b1);
      if (cls == 4) return;
    end

    new_step();
    e.reg_we = 1; e.reg_dst = (cls == 1); e.mem_to_reg = (cls == 3);
    m.reg_dst = 1; m.mem_to_reg = 1;
    push(d, "wback", S_WBACK, ins, zf, of, 1'($urandom_range(0, 1)));
  endtask

  // Play n queued steps (all when n < 0): drive after negedge, compare 1ns later
  task automatic run_q(input int d, input int n);
    step_t s;
    int done = 0;
    while (q.size() > 0 && (n < 0 || done < n)) begin
      s = q.pop_front();
      @(negedge CLK);
      instr_v[d] = s.instr; zf_v[d] = s.zf; of_v[d] = s.of; rdy_v[d] = s.rdy;
      #1;
      chk(s.tag, {obs_v[d] & s.msk, st_v[d]}, {s.exp & s.msk, s.st});
      done++;
    end
  endtask

  task automatic run_instr(input int d, input logic [31:0] ins, input int lf, input int lm,
                           input logic zf, input logic of);
    gen(d, ins, lf, lm, zf, of);
    run_q(d, -1);
  endtask

  function automatic obs_t rst_vec();
    obs_t r = '0;
    r.alu_op = 3'b100;
    return r;
  endfunction

  task automatic do_reset(input int d);
    q.delete();
    @(negedge CLK);
    rst_n_v[d] = 1'b0; rdy_v[d] = 1'b0;
    m_cause[d] = 2'b00;
    #1 chk("rst_hold", {obs_v[d], st_v[d]}, {rst_vec(), S_RESET});
    @(negedge CLK);
    rst_n_v[d] = 1'b1;
    #1 chk("rst_cycle", {obs_v[d], st_v[d]}, {rst_vec(), S_RESET});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] rfn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
    logic [5:0] bad_op [7] = '{6'h01, 6'h03, 6'h06, 6'h09, 6'h0F, 6'h20, 6'h3F};
    logic [5:0] bad_fn [5] = '{6'h21, 6'h23, 6'h00, 6'h08, 6'h2A};
    logic [5:0] iop [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
    int k = $urandom_range(0, 15);
    r = $urandom;
    if (k <= 7)       begin r[31:26] = 6'h00; r[5:0] = rfn[k]; end
    else if (k <= 9)  r[31:26] = iop[$urandom_range(0, 3)];
    else if (k == 10) r[31:26] = 6'h23;
    else if (k == 11) r[31:26] = 6'h2B;
    else if (k == 12) r[31:26] = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
    else if (k == 13) r[31:26] = 6'h02;
    else if (k == 14) r[31:26] = bad_op[$urandom_range(0, 6)];
    else              begin r[31:26] = 6'h00; r[5:0] = bad_fn[$urandom_range(0, 4)]; end
    return r;
  endfunction

  task automatic rand_run(input int d, input int cnt);
    for (int i = 0; i < cnt; i++)
      run_instr(d, rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; instr_v[i] = '0; zf_v[i] = 0; of_v[i] = 0; rdy_v[i] = 0; m_cause[i] = 0;
    end
    #12;

    // Instance A: traps on overflow/illegal, no bus timeout
    do_reset(0);
    run_instr(0, 32'h00221820, 0, 0, 1'b0, 1'b0);  // add, clean writeback
    run_instr(0, 32'h00221820, 1, 0, 1'b0, 1'b1);  // add overflow -> trap 01
    run_instr(0, 32'h10220003, 0, 0, 1'b1, 1'b0);  // beq taken
    run_instr(0, 32'h10220003, 0, 0, 1'b0, 1'b0);  // beq not taken
    run_instr(0, 32'h14220003, 0, 0, 1'b1, 1'b0);  // bne not taken
    run_instr(0, 32'h14220003, 0, 0, 1'b0, 1'b0);  // bne taken
    run_instr(0, 32'h8C230004, 0, 3, 1'b0, 1'b1);  // lw, 3 wait cycles
    run_instr(0, 32'hFC000000, 0, 0, 1'b0, 1'b0);  // opcode 3F -> trap 10
    run_instr(0, 32'h00221821, 0, 0, 1'b0, 1'b0);  // addu -> trap 10
    run_instr(0, 32'h34230F0F, 0, 0, 1'b0, 1'b1);  // ori, zero-ext
    run_instr(0, 32'h08000010, 2, 0, 1'b0, 1'b0);  // j
    run_instr(0, 32'hAC230008, 0, 1, 1'b0, 1'b0);  // sw
    rand_run(0, 150);

    // Reset while sw is waiting in MEMACC: request drops immediately
    gen(0, 32'hAC230008, 0, 5, 1'b0, 1'b0);
    run_q(0, 4);
    q.delete();
    #2 rst_n_v[0] = 1'b0;
    m_cause[0] = 2'b00;
    #1 chk("rst_mid_memacc", {obs_v[0], st_v[0]}, {rst_vec(), S_RESET});
    @(negedge CLK);
    rst_n_v[0] = 1'b1; rdy_v[0] = 1'b0;
    #1 chk("rst_after_memacc", {obs_v[0], st_v[0]}, {rst_vec(), S_RESET});
    run_instr(0, 32'h00221820, 1, 0, 1'b0, 1'b0);

    // Instance B: overflow ignored, illegal as NOP, timeout after 2 low cycles
    do_reset(1);
    run_instr(1, 32'h00221820, 0, 0, 1'b0, 1'b1);  // add overflow -> writeback
    run_instr(1, 32'h8C230004, 0, 3, 1'b0, 1'b0);  // lw times out -> trap 11
    run_instr(1, 32'h00221820, 3, 0, 1'b0, 1'b0);  // fetch times out -> trap 11
    run_instr(1, 32'hFC000000, 0, 0, 1'b0, 1'b0);  // illegal -> NOP
    run_instr(1, 32'h8C230004, 1, 1, 1'b0, 1'b0);  // one low cycle each, no timeout
    rand_run(1, 150);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
